// File: rtl/dump_switch_ctrl.sv
// Break-before-make sequencer for the coil dump-stage power switches plus the dump-window timer.
// Optional DUMP_SWITCH_PULSE_CNT_EN adds pulse_cnt, a saturating count of entries into ON.
module dump_switch_ctrl #(
  parameter int DW = 8,
  parameter int TW = 16
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          en,
  input  logic          off_start,
  input  logic          on_start,
  input  logic          timer_start,
  input  logic [DW-1:0] dead_cnt,
  input  logic [TW-1:0] min_on_cnt,
  input  logic [TW-1:0] dump_time,
`ifdef DUMP_SWITCH_PULSE_CNT_EN
  output logic [7:0]    pulse_cnt,
`endif
  output logic          gate_on,
  output logic          gate_off,
  output logic          busy,
  output logic          fault,
  output logic          dump_done
);

  typedef enum logic [2:0] {IDLE, DT_ON, ON, DT_OFF, OFF, FAULT} state_t;

  state_t        state_reg;
  logic [DW-1:0] dead_reg;
  logic [TW-1:0] on_cnt_reg;
  logic          pending_reg;
  logic          gate_on_reg;
  logic          gate_off_reg;
  logic          busy_reg;
  logic          fault_reg;
  logic [TW-1:0] timer_cnt_reg;
  logic          timer_prev_reg;
  logic          dump_done_reg;
  logic          srst;
  logic          req_on;
  logic          req_off;
  logic          req_both;
  logic          req_none;
  logic          timer_rise;
`ifdef DUMP_SWITCH_PULSE_CNT_EN
  logic [7:0]    pulse_cnt_reg;
  assign pulse_cnt = pulse_cnt_reg;
`endif

  assign srst       = !rst_n || !en;
  assign req_on     = on_start && !off_start;
  assign req_off    = off_start && !on_start;
  assign req_both   = on_start && off_start;
  assign req_none   = !on_start && !off_start;
  assign timer_rise = timer_start && !timer_prev_reg;

  assign gate_on   = gate_on_reg;
  assign gate_off  = gate_off_reg;
  assign busy      = busy_reg;
  assign fault     = fault_reg;
  assign dump_done = dump_done_reg;

  always_ff @(posedge clk_sys) begin
    if (srst) begin
      state_reg     <= IDLE;
      dead_reg      <= '0;
      on_cnt_reg    <= '0;
      pending_reg   <= 1'b0;
      gate_on_reg   <= 1'b0;
      gate_off_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      fault_reg     <= 1'b0;
`ifdef DUMP_SWITCH_PULSE_CNT_EN
      pulse_cnt_reg <= '0;
`endif
    end else begin
      if (req_both) begin
        state_reg    <= FAULT;
        gate_on_reg  <= 1'b0;
        gate_off_reg <= 1'b0;
        busy_reg     <= 1'b1;
        fault_reg    <= 1'b1;
        pending_reg  <= 1'b0;
      end else if (req_none && state_reg != IDLE) begin
        // Dropping gates needs no dead time and waives min-on; also the FAULT exit.
        state_reg    <= IDLE;
        gate_on_reg  <= 1'b0;
        gate_off_reg <= 1'b0;
        busy_reg     <= 1'b0;
        fault_reg    <= 1'b0;
        pending_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (req_on) begin
              state_reg <= DT_ON;
              dead_reg  <= dead_cnt;
              busy_reg  <= 1'b1;
            end else if (req_off) begin
              state_reg <= DT_OFF;
              dead_reg  <= dead_cnt;
              busy_reg  <= 1'b1;
            end
          end
          DT_ON: begin
            if (dead_reg == '0) begin
              state_reg   <= ON;
              gate_on_reg <= 1'b1;
              on_cnt_reg  <= TW'(1);
              pending_reg <= 1'b0;
`ifdef DUMP_SWITCH_PULSE_CNT_EN
              if (pulse_cnt_reg != 8'hFF) pulse_cnt_reg <= pulse_cnt_reg + 8'd1;
`endif
            end else begin
              dead_reg <= dead_reg - 1'b1;
            end
          end
          ON: begin
            if (on_cnt_reg != '1) on_cnt_reg <= on_cnt_reg + 1'b1;
            // on_cnt_reg holds the number of cycles gate_on has already been high.
            if ((pending_reg || req_off) && on_cnt_reg >= min_on_cnt) begin
              state_reg   <= DT_OFF;
              dead_reg    <= dead_cnt;
              gate_on_reg <= 1'b0;
              pending_reg <= 1'b0;
            end else if (req_off) begin
              pending_reg <= 1'b1;
            end else if (req_on) begin
              pending_reg <= 1'b0;
            end
          end
          DT_OFF: begin
            if (dead_reg == '0) begin
              state_reg    <= OFF;
              gate_off_reg <= 1'b1;
            end else begin
              dead_reg <= dead_reg - 1'b1;
            end
          end
          OFF: begin
            if (req_on) begin
              state_reg    <= DT_ON;
              dead_reg     <= dead_cnt;
              gate_off_reg <= 1'b0;
            end
          end
          FAULT: begin
            state_reg <= FAULT;
          end
          default: begin
            state_reg    <= IDLE;
            gate_on_reg  <= 1'b0;
            gate_off_reg <= 1'b0;
            busy_reg     <= 1'b0;
            fault_reg    <= 1'b0;
          end
        endcase
      end
`ifdef DUMP_SWITCH_PULSE_CNT_EN
      if (timer_rise) pulse_cnt_reg <= '0;
`endif
    end
  end

  // Dump-window timer runs independently of the gate FSM, including through FAULT.
  always_ff @(posedge clk_sys) begin
    if (srst) begin
      timer_cnt_reg  <= '0;
      timer_prev_reg <= 1'b0;
      dump_done_reg  <= 1'b0;
    end else begin
      timer_prev_reg <= timer_start;
      if (!timer_start) begin
        timer_cnt_reg <= '0;
        dump_done_reg <= 1'b0;
      end else if (timer_rise) begin
        timer_cnt_reg <= '0;
      end else begin
        if (timer_cnt_reg != '1) timer_cnt_reg <= timer_cnt_reg + 1'b1;
        if (dump_time == '0 || timer_cnt_reg >= dump_time - 1'b1) dump_done_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dump_switch_ctrl.sv
// Directed testbench for dump_switch_ctrl: gate sequencing, dead/min-on timing, fault, timer, reset.
module tb_dump_switch_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        off_start = 1'b0;
  logic        on_start = 1'b0;
  logic        timer_start = 1'b0;
  logic [7:0]  dead_cnt = 8'd3;
  logic [15:0] min_on_cnt = 16'd20;
  logic [15:0] dump_time = 16'd100;
  logic        gate_on;
  logic        gate_off;
  logic        busy;
  logic        fault;
  logic        dump_done;
`ifdef DUMP_SWITCH_PULSE_CNT_EN
  logic [7:0]  pulse_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  dump_switch_ctrl #(.DW(8), .TW(16)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .en          (en),
    .off_start   (off_start),
    .on_start    (on_start),
    .timer_start (timer_start),
    .dead_cnt    (dead_cnt),
    .min_on_cnt  (min_on_cnt),
    .dump_time   (dump_time),
`ifdef DUMP_SWITCH_PULSE_CNT_EN
    .pulse_cnt   (pulse_cnt),
`endif
    .gate_on     (gate_on),
    .gate_off    (gate_off),
    .busy        (busy),
    .fault       (fault),
    .dump_done   (dump_done)
  );

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({gate_on, gate_off, busy, fault, dump_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset outputs={on,off,busy,fault,done}=%b expected 00000",
               {gate_on, gate_off, busy, fault, dump_done});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b expected 0", busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_dead_on;
    dead_cnt = 8'd3;
    on_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gate_on !== (i == 4) || gate_off !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL dead_on cycle %0d on=%b off=%b busy=%b expected on=%b off=0 busy=1",
                 i, gate_on, gate_off, busy, i == 4);
      end
    end
    $display("test_dead_on done");
  endtask

  task automatic test_min_on;
    min_on_cnt = 16'd20;
    for (int j = 1; j <= 5; j++) tick();
    on_start  = 1'b0;
    off_start = 1'b1;
    for (int j = 6; j <= 20; j++) begin
      tick();
      checks++;
      if (gate_on !== (j < 20) || gate_off !== 1'b0) begin
        errors++;
        $display("FAIL min_on cycle %0d on=%b off=%b expected on=%b off=0", j, gate_on, gate_off, j < 20);
      end
    end
    for (int j = 21; j <= 24; j++) begin
      tick();
      checks++;
      if (gate_off !== (j == 24) || gate_on !== 1'b0) begin
        errors++;
        $display("FAIL dead_off cycle %0d on=%b off=%b expected on=0 off=%b", j, gate_on, gate_off, j == 24);
      end
    end
    $display("test_min_on done");
  endtask

  task automatic test_fault;
    dead_cnt  = 8'd0;
    off_start = 1'b0;
    on_start  = 1'b1;
    tick();
    checks++;
    if (gate_off !== 1'b0 || gate_on !== 1'b0) begin
      errors++;
      $display("FAIL off_to_dt on=%b off=%b expected 0 0", gate_on, gate_off);
    end
    tick();
    checks++;
    if (gate_on !== 1'b1) begin
      errors++;
      $display("FAIL fault_setup_on gate_on=%b expected 1", gate_on);
    end
    off_start = 1'b1;
    tick();
    checks++;
    if (gate_on !== 1'b0 || gate_off !== 1'b0 || fault !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fault_enter on=%b off=%b fault=%b busy=%b expected 0 0 1 1", gate_on, gate_off, fault, busy);
    end
    on_start = 1'b0;
    tick();
    checks++;
    if (fault !== 1'b1 || gate_off !== 1'b0) begin
      errors++;
      $display("FAIL fault_hold fault=%b off=%b expected 1 0", fault, gate_off);
    end
    off_start = 1'b0;
    tick();
    checks++;
    if (fault !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fault_exit fault=%b busy=%b expected 0 0", fault, busy);
    end
    $display("test_fault done");
  endtask

  task automatic test_pending_cancel;
    dead_cnt   = 8'd0;
    min_on_cnt = 16'd10;
    on_start   = 1'b1;
    tick();
    tick();
    checks++;
    if (gate_on !== 1'b1) begin
      errors++;
      $display("FAIL cancel_on gate_on=%b expected 1", gate_on);
    end
    tick();
    tick();
    on_start  = 1'b0;
    off_start = 1'b1;
    tick();
    on_start  = 1'b1;
    off_start = 1'b0;
    tick();
    for (int j = 5; j <= 12; j++) begin
      tick();
      checks++;
      if (gate_on !== 1'b1) begin
        errors++;
        $display("FAIL cancel_hold cycle %0d gate_on=%b expected 1", j, gate_on);
      end
    end
    on_start = 1'b0;
    tick();
    checks++;
    if (gate_on !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_release on=%b busy=%b expected 0 0", gate_on, busy);
    end
    $display("test_pending_cancel done");
  endtask

  task automatic test_waive_and_en;
    min_on_cnt = 16'd10;
    on_start   = 1'b1;
    tick();
    tick();
    on_start = 1'b0;
    tick();
    checks++;
    if (gate_on !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL min_on_waive on=%b busy=%b expected 0 0", gate_on, busy);
    end
    on_start = 1'b1;
    tick();
    tick();
    en = 1'b0;
    tick();
    checks++;
    if (gate_on !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_low on=%b busy=%b expected 0 0", gate_on, busy);
    end
    en       = 1'b1;
    on_start = 1'b0;
    tick();
    $display("test_waive_and_en done");
  endtask

  task automatic test_timer;
    dump_time   = 16'd100;
    timer_start = 1'b1;
    for (int j = 0; j <= 101; j++) begin
      tick();
      checks++;
      if (dump_done !== (j >= 100)) begin
        errors++;
        $display("FAIL timer edge %0d dump_done=%b expected %b", j, dump_done, j >= 100);
      end
    end
    timer_start = 1'b0;
    tick();
    checks++;
    if (dump_done !== 1'b0) begin
      errors++;
      $display("FAIL timer_clear dump_done=%b expected 0", dump_done);
    end
    dump_time   = 16'd0;
    timer_start = 1'b1;
    tick();
    checks++;
    if (dump_done !== 1'b0) begin
      errors++;
      $display("FAIL timer_zero_rise dump_done=%b expected 0", dump_done);
    end
    tick();
    checks++;
    if (dump_done !== 1'b1) begin
      errors++;
      $display("FAIL timer_zero dump_done=%b expected 1", dump_done);
    end
    timer_start = 1'b0;
    dump_time   = 16'd100;
    tick();
    $display("test_timer done");
  endtask

  task automatic test_reset_mid;
    dead_cnt    = 8'd3;
    off_start   = 1'b1;
    timer_start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (gate_off !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup gate_off=%b expected 1", gate_off);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({gate_on, gate_off, busy, fault, dump_done} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset outputs={on,off,busy,fault,done}=%b expected 00000",
               {gate_on, gate_off, busy, fault, dump_done});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gate_off !== (i == 4) || busy !== 1'b1) begin
        errors++;
        $display("FAIL mid_restart cycle %0d off=%b busy=%b expected off=%b busy=1", i, gate_off, busy, i == 4);
      end
    end
    off_start   = 1'b0;
    timer_start = 1'b0;
    tick();
    $display("test_reset_mid done");
  endtask

`ifdef DUMP_SWITCH_PULSE_CNT_EN
  task automatic test_pulse_cnt;
    dead_cnt = 8'd0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      on_start = 1'b1;
      tick();
      tick();
      on_start = 1'b0;
      tick();
      if (n == 1) begin
        checks++;
        if (pulse_cnt !== 8'd1) begin
          errors++;
          $display("FAIL pulse_first pulse_cnt=%0d expected 1", pulse_cnt);
        end
      end
    end
    checks++;
    if (pulse_cnt !== 8'd255) begin
      errors++;
      $display("FAIL pulse_sat pulse_cnt=%0d expected 255", pulse_cnt);
    end
    timer_start = 1'b1;
    tick();
    checks++;
    if (pulse_cnt !== 8'd0) begin
      errors++;
      $display("FAIL pulse_clear pulse_cnt=%0d expected 0", pulse_cnt);
    end
    timer_start = 1'b0;
    tick();
    $display("test_pulse_cnt done");
  endtask
`endif

  initial begin
    test_reset();
    test_dead_on();
    test_min_on();
    test_fault();
    test_pending_cancel();
    test_waive_and_en();
    test_timer();
    test_reset_mid();
`ifdef DUMP_SWITCH_PULSE_CNT_EN
    test_pulse_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
